// File: rtl/bus_arbiter_rr.sv
// N-way round-robin arbiter: registers the winning master's request onto one
// downstream port, tags it with o_id and aborts stalled transfers via a watchdog.
module bus_arbiter_rr #(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_MASTERS-1:0]  i_bus_en,
    input  logic [N_MASTERS-1:0]  i_wr_en,
    input  logic [N_MASTERS*XLEN-1:0] i_wr_data,
    input  logic [N_MASTERS*XLEN-1:0] i_addr,
    input  logic [N_MASTERS*4-1:0]    i_byte_en,
    input  logic [N_MASTERS-1:0]  i_atomic,
    input  logic [N_MASTERS*7-1:0]    i_operation,
    output logic [N_MASTERS-1:0]  o_ack,
    output logic [XLEN-1:0]       o_rd_data,
    output logic                  o_timeout,
    input  logic                  i_ack,
    input  logic [XLEN-1:0]       i_rd_data,
    output logic [((N_MASTERS > 1) ? $clog2(N_MASTERS) : 1)-1:0] o_id,
    output logic                  o_bus_en,
    output logic                  o_wr_en,
    output logic [XLEN-1:0]       o_wr_data,
    output logic [XLEN-1:0]       o_addr,
    output logic [3:0]            o_byte_en,
    output logic                  o_atomic,
    output logic [6:0]            o_operation
);

    localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST =
        (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t r_state, w_state_nxt;

    logic [IDW-1:0]       r_ptr;
    logic [WDW-1:0]       r_wdog;
    logic [IDW-1:0]       r_id;
    logic                 r_bus_en;
    logic                 r_wr_en;
    logic [XLEN-1:0]      r_wr_data;
    logic [XLEN-1:0]      r_addr;
    logic [3:0]           r_byte_en;
    logic                 r_atomic;
    logic [6:0]           r_operation;

    logic [2*N_MASTERS-1:0] w_dbl;
    logic [N_MASTERS-1:0]   w_rot;
    logic [IDW-1:0]         w_off;
    logic [IDW:0]           w_sum;
    logic [IDW-1:0]         w_win;
    logic                   w_any;
    logic                   w_tmo;
    logic                   w_done;
    logic [N_MASTERS-1:0]   w_ack;

    // Rotate requests so bit 0 is the current highest-priority master.
    always_comb begin
        w_dbl = {i_bus_en, i_bus_en};
        w_rot = N_MASTERS'(w_dbl >> r_ptr);
        w_any = |w_rot;
        w_off = '0;
        for (int j = N_MASTERS - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = IDW'(j);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(N_MASTERS))
            w_sum = w_sum - (IDW+1)'(N_MASTERS);
        w_win = w_sum[IDW-1:0];
    end

    // Ack beats watchdog when both land in the same cycle.
    assign w_tmo  = (TIMEOUT != 0) && (r_state == S_BUSY) &&
                    !i_ack && (r_wdog == WD_LAST);
    assign w_done = (r_state == S_BUSY) && (i_ack || w_tmo);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_any)  w_state_nxt = S_BUSY;
            S_BUSY: if (w_done) w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack = '0;
        if (w_done) w_ack[r_id] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_wdog      <= '0;
            r_id        <= '0;
            r_bus_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_addr      <= '0;
            r_byte_en   <= '0;
            r_atomic    <= 1'b0;
            r_operation <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any) begin
                r_id        <= w_win;
                r_bus_en    <= 1'b1;
                r_wr_en     <= i_wr_en[w_win];
                r_wr_data   <= i_wr_data[w_win*XLEN +: XLEN];
                r_addr      <= i_addr[w_win*XLEN +: XLEN];
                r_byte_en   <= i_byte_en[w_win*4 +: 4];
                r_atomic    <= i_atomic[w_win];
                r_operation <= i_operation[w_win*7 +: 7];
                r_wdog      <= '0;
            end
        end else if (w_done) begin
            r_ptr       <= (r_id == IDW'(N_MASTERS - 1)) ? '0 : r_id + 1'b1;
            r_wdog      <= '0;
            r_id        <= '0;
            r_bus_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_addr      <= '0;
            r_byte_en   <= '0;
            r_atomic    <= 1'b0;
            r_operation <= '0;
        end else if (r_wdog != '1) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign o_ack       = w_ack;
    assign o_rd_data   = ((r_state == S_BUSY) && i_ack) ? i_rd_data : '0;
    assign o_timeout   = w_tmo;
    assign o_id        = r_id;
    assign o_bus_en    = r_bus_en;
    assign o_wr_en     = r_wr_en;
    assign o_wr_data   = r_wr_data;
    assign o_addr      = r_addr;
    assign o_byte_en   = r_byte_en;
    assign o_atomic    = r_atomic;
    assign o_operation = r_operation;

endmodule
